// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: arbiter state and OWNER encodings shared by the SDRAM arbiter files.
package sdram_arbiter_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GNT_CPU,
      ST_GNT_DMA,
      ST_REF_ISSUE,
      ST_REF_WAIT,
      ST_LOCK_HOLD
   } state_t;
   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_CPU  = 2'b01,
      OWN_DMA  = 2'b10,
      OWN_REF  = 2'b11
   } owner_t;
   function automatic owner_t state_owner(input state_t s);
      return (s == ST_GNT_CPU || s == ST_LOCK_HOLD) ? OWN_CPU :
             (s == ST_GNT_DMA) ? OWN_DMA :
             (s == ST_REF_ISSUE || s == ST_REF_WAIT) ? OWN_REF : OWN_NONE;
   endfunction
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: refresh interval counter and saturating refresh-debt counter.
module sdram_refresh_timer
   import sdram_arbiter_pkg::*;
#(
   parameter int REF_INTERVAL = 390,
   parameter int MAX_PENDING  = 8,
   parameter int PEND_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_busy,
   input  logic              ref_done,
   output logic [PEND_W-1:0] pending
);
   localparam int CNT_W = $clog2(REF_INTERVAL + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INTERVAL - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic tick;
   always_comb begin
      tick   = !init_busy && cnt_q == CNT_LAST;
      cnt_d  = (init_busy || tick) ? '0 : cnt_q + 1'b1;
      // a tick and a completed refresh in the same cycle cancel out
      pend_d = (tick && !ref_done && pend_q != PEND_MAX) ? pend_q + 1'b1 :
               (ref_done && !tick && pend_q != '0) ? pend_q - 1'b1 : pend_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         pend_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end
   assign pending = pend_q;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: picks CPU, DMA or auto-refresh as owner of the next SDRAM cycle.
// Optional CPU read-modify-write lock enabled by defining SDRAM_ARB_LOCK_EN.
module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int REF_INTERVAL = 390,
   parameter int MAX_PENDING  = 8,
   parameter int PEND_W       = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              INIT_BUSY,
   input  logic              CTRL_IDLE,
   input  logic              CTRL_DONE,
   input  logic              CPU_REQ,
   input  logic              CPU_LOCK,
   input  logic              DMA_REQ,
   output logic              CPU_GNT,
   output logic              DMA_GNT,
   output logic              REF_GO,
   output logic [PEND_W-1:0] REF_PENDING,
   output logic [1:0]        OWNER
);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
   state_t state_q, state_d;
   logic last_cpu_q, last_cpu_d;
   logic ref_done, urgent, pick_cpu;
   sdram_refresh_timer #(
      .REF_INTERVAL(REF_INTERVAL),
      .MAX_PENDING (MAX_PENDING),
      .PEND_W      (PEND_W)
   ) u_tmr (
      .clk      (CLK),
      .rst_n    (RESET),
      .init_busy(INIT_BUSY),
      .ref_done (ref_done),
      .pending  (REF_PENDING)
   );
`ifndef SDRAM_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = CPU_LOCK;
`endif
   always_comb begin
      state_d    = state_q;
      last_cpu_d = last_cpu_q;
      ref_done   = 1'b0;
      urgent     = REF_PENDING == PEND_MAX;
      // on a tie the CPU wins only if DMA was served last
      pick_cpu   = CPU_REQ && (!DMA_REQ || !last_cpu_q);
      case (state_q)
         ST_IDLE:
            if (!INIT_BUSY && CTRL_IDLE)
               state_d = urgent ? ST_REF_ISSUE : pick_cpu ? ST_GNT_CPU : DMA_REQ ? ST_GNT_DMA :
                         (REF_PENDING != '0) ? ST_REF_ISSUE : ST_IDLE;
         ST_GNT_CPU:
            if (CTRL_DONE) begin
               last_cpu_d = 1'b1;
`ifdef SDRAM_ARB_LOCK_EN
               state_d    = CPU_LOCK ? ST_LOCK_HOLD : ST_IDLE;
`else
               state_d    = ST_IDLE;
`endif
            end
         ST_GNT_DMA:
            if (CTRL_DONE) begin
               last_cpu_d = 1'b0;
               state_d    = ST_IDLE;
            end
         ST_REF_ISSUE: state_d = ST_REF_WAIT;
         ST_REF_WAIT:
            if (CTRL_DONE) begin
               ref_done = 1'b1;
               state_d  = ST_IDLE;
            end
`ifdef SDRAM_ARB_LOCK_EN
         ST_LOCK_HOLD:
            state_d = !CPU_LOCK ? ST_IDLE : (CTRL_IDLE && CPU_REQ) ? ST_GNT_CPU : ST_LOCK_HOLD;
`endif
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= ST_IDLE;
         last_cpu_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_cpu_q <= last_cpu_d;
      end
   end
   assign OWNER   = state_owner(state_q);
   assign CPU_GNT = OWNER == OWN_CPU;
   assign DMA_GNT = OWNER == OWN_DMA;
   assign REF_GO  = state_q == ST_REF_ISSUE;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter with a short refresh interval.
module tb_sdram_arbiter;
   import sdram_arbiter_pkg::*;
   localparam int LAT = 4;
   logic CLK = 0, RESET = 1, INIT_BUSY = 0, CTRL_IDLE = 1, CPU_REQ = 0, CPU_LOCK = 0, DMA_REQ = 0;
   logic CPU_GNT, DMA_GNT, REF_GO, CTRL_DONE;
   logic [3:0] REF_PENDING;
   logic [1:0] OWNER;
   logic auto_en = 1, auto_done = 0, man_done = 0;
   int n_tests = 0, n_fail = 0, sb_tests = 0, sb_fail = 0, rcnt = 0;
   logic [1:0] exp_q[$];
   assign CTRL_DONE = auto_done | man_done;
   always #5 CLK = ~CLK;
   sdram_arbiter #(.REF_INTERVAL(16), .MAX_PENDING(8), .PEND_W(4)) dut (
      .CLK(CLK), .RESET(RESET), .INIT_BUSY(INIT_BUSY), .CTRL_IDLE(CTRL_IDLE),
      .CTRL_DONE(CTRL_DONE), .CPU_REQ(CPU_REQ), .CPU_LOCK(CPU_LOCK), .DMA_REQ(DMA_REQ),
      .CPU_GNT(CPU_GNT), .DMA_GNT(DMA_GNT), .REF_GO(REF_GO),
      .REF_PENDING(REF_PENDING), .OWNER(OWNER)
   );
   // controller model: pulses DONE after LAT cycles of ownership
   always @(negedge CLK) begin
      if (!RESET || !auto_en || auto_done) begin
         auto_done = 0;
         rcnt = 0;
      end else if (OWNER != OWN_NONE) begin
         if (rcnt == LAT - 1) auto_done = 1;
         else rcnt++;
      end
   end
   always @(negedge CLK) begin : mon
      logic [1:0] ev, e;
      logic hit, p_cpu, p_dma, p_any;
      if (!RESET) begin
         p_cpu = 0;
         p_dma = 0;
         p_any = 0;
      end else begin
         sb_tests++;
         if ((CPU_GNT && DMA_GNT) || REF_PENDING > 8 || CPU_GNT != (OWNER == OWN_CPU) ||
             DMA_GNT != (OWNER == OWN_DMA) || (REF_GO && OWNER != OWN_REF)) begin
            sb_fail++;
            $display("FAIL invariant: cpu=%0b dma=%0b ref_go=%0b owner=%0d pending=%0d", CPU_GNT, DMA_GNT, REF_GO, OWNER, REF_PENDING);
         end
         hit = 1;
         ev = OWN_NONE;
         if (CPU_GNT && !p_cpu) ev = OWN_CPU;
         else if (DMA_GNT && !p_dma) ev = OWN_DMA;
         else if (REF_GO) ev = OWN_REF;
         else hit = 0;
         if (hit) begin
            sb_tests++;
            if (exp_q.size() == 0) begin
               sb_fail++;
               $display("FAIL sb_unexpected: got owner %0d, expected no event", ev);
            end else begin
               e = exp_q.pop_front();
               if (e != ev) begin
                  sb_fail++;
                  $display("FAIL sb_order: got owner %0d, expected %0d", ev, e);
               end
            end
            if (ev != OWN_REF) begin
               sb_tests++;
               if (p_any) begin
                  sb_fail++;
                  $display("FAIL dead_cycle: got grant in previous cycle 1, expected 0");
               end
            end
         end
         p_cpu = CPU_GNT;
         p_dma = DMA_GNT;
         p_any = CPU_GNT | DMA_GNT;
      end
   end
   task automatic chk(input string nm, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask
   task automatic do_reset(input logic init, input logic idle, input logic creq, input logic dreq);
      @(negedge CLK);
      chk("sb_drained", exp_q.size(), 0);
      exp_q.delete();
      RESET = 0;
      INIT_BUSY = init;
      CTRL_IDLE = idle;
      CPU_REQ = creq;
      DMA_REQ = dreq;
      man_done = 0;
      auto_en = 1;
      cyc(2);
      RESET = 1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog timeout");
   end
   initial begin
      #1 RESET = 0;
      // init gating
      do_reset(1, 1, 1, 0);
      chk("rst_cpu_gnt", CPU_GNT, 0);
      chk("rst_dma_gnt", DMA_GNT, 0);
      chk("rst_ref_go", REF_GO, 0);
      chk("rst_owner", OWNER, 0);
      chk("rst_pending", REF_PENDING, 0);
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         chk("init_no_gnt", CPU_GNT, 0);
         chk("init_timer", dut.u_tmr.cnt_q, 0);
      end
      exp_q.push_back(OWN_CPU);
      INIT_BUSY = 0;
      cyc(1);
      chk("init_gnt", CPU_GNT, 1);
      chk("init_owner", OWNER, OWN_CPU);
      CPU_REQ = 0;
      cyc(2);
      chk("no_abort", CPU_GNT, 1);
      cyc(2);
      chk("gnt_drop", CPU_GNT, 0);
      cyc(1);
      chk("no_regrant", OWNER, OWN_NONE);
      // opportunistic refresh
      do_reset(0, 1, 0, 0);
      exp_q.push_back(OWN_REF);
      cyc(15);
      chk("opp_pend0", REF_PENDING, 0);
      cyc(1);
      chk("opp_pend1", REF_PENDING, 1);
      chk("opp_go_early", REF_GO, 0);
      cyc(1);
      chk("opp_go", REF_GO, 1);
      chk("opp_owner", OWNER, OWN_REF);
      cyc(1);
      chk("opp_go_pulse", REF_GO, 0);
      chk("opp_wait_owner", OWNER, OWN_REF);
      cyc(3);
      chk("opp_pend_done", REF_PENDING, 0);
      chk("opp_owner_done", OWNER, OWN_NONE);
      // round-robin, then opportunistic refresh once requests stop
      do_reset(0, 1, 1, 1);
      exp_q.push_back(OWN_CPU);
      exp_q.push_back(OWN_DMA);
      exp_q.push_back(OWN_CPU);
      exp_q.push_back(OWN_DMA);
      exp_q.push_back(OWN_REF);
      cyc(16);
      chk("rr_dma2", DMA_GNT, 1);
      CPU_REQ = 0;
      DMA_REQ = 0;
      cyc(4);
      chk("rr_dead", OWNER, OWN_NONE);
      chk("rr_pend", REF_PENDING, 1);
      cyc(1);
      chk("rr_ref_go", REF_GO, 1);
      cyc(4);
      chk("rr_pend_done", REF_PENDING, 0);
      // urgent refresh pre-empts DMA, then async reset mid-grant
      do_reset(0, 1, 0, 1);
      for (int i = 0; i < 26; i++) exp_q.push_back(OWN_DMA);
      exp_q.push_back(OWN_REF);
      exp_q.push_back(OWN_DMA);
      cyc(130);
      chk("urg_pend", REF_PENDING, 8);
      chk("urg_idle", OWNER, OWN_NONE);
      cyc(1);
      chk("urg_ref_go", REF_GO, 1);
      chk("urg_no_dma", DMA_GNT, 0);
      cyc(5);
      chk("urg_dma_back", DMA_GNT, 1);
      chk("urg_pend_dec", REF_PENDING, 7);
      cyc(1);
      #1 RESET = 0;
      #1;
      chk("arst_dma", DMA_GNT, 0);
      chk("arst_owner", OWNER, OWN_NONE);
      chk("arst_pend", REF_PENDING, 0);
      // saturation with the controller never idle
      do_reset(0, 0, 0, 0);
      cyc(150);
      chk("sat_pend", REF_PENDING, 8);
      chk("sat_owner", OWNER, OWN_NONE);
      // DONE in IDLE ignored; tick and refresh DONE in the same cycle
      do_reset(0, 0, 0, 0);
      auto_en = 0;
      cyc(40);
      man_done = 1;
      cyc(1);
      man_done = 0;
      cyc(9);
      chk("tick_pend3", REF_PENDING, 3);
      exp_q.push_back(OWN_REF);
      CTRL_IDLE = 1;
      cyc(1);
      chk("tick_ref_go", REF_GO, 1);
      cyc(12);
      chk("tick_wait", OWNER, OWN_REF);
      man_done = 1;
      cyc(1);
      chk("tick_done_pend", REF_PENDING, 3);
      chk("tick_done_owner", OWNER, OWN_NONE);
      man_done = 0;
      CTRL_IDLE = 0;
      cyc(2);
      chk("sb_final", exp_q.size(), 0);
      n_tests += sb_tests;
      n_fail += sb_fail;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sequences the SDRAM controller by deciding which requester owns the next SDRAM cycle: the CPU port, a secondary DMA/bus-master port, or an auto-refresh.
- Contains the refresh-interval timer and a bounded postponed-refresh counter.
- Sits between the requesters and the SDRAM command sequencer, on the SDRAM clock domain.

Parameters:
- REF_INTERVAL, 390: SDRAM clocks between refresh ticks (~7.8 us at 50 MHz).
- MAX_PENDING, 8: refresh debt at which refresh becomes urgent and pre-empts arbitration.
- PEND_W, 4: width of the pending counter; must hold MAX_PENDING.

Ports:
- CLK in 1: SDRAM clock; all logic on the rising edge.
- RESET in 1: asynchronous, active-low reset.
- INIT_BUSY in 1: high while the SDRAM init sequence runs; no grants and no refresh issued while high.
- CTRL_IDLE in 1: controller is idle and can accept a new cycle.
- CTRL_DONE in 1: one-cycle pulse when the granted cycle (access or refresh) completes.
- CPU_REQ in 1: CPU requests an SDRAM cycle; level, held until granted and done.
- CPU_LOCK in 1: CPU read-modify-write lock (used only with the optional feature).
- DMA_REQ in 1: DMA requests an SDRAM cycle; level.
- CPU_GNT out 1: CPU owns the controller.
- DMA_GNT out 1: DMA owns the controller.
- REF_GO out 1: one-cycle pulse commanding an auto-refresh.
- REF_PENDING out PEND_W: current refresh debt.
- OWNER out 2: 00 none, 01 CPU, 10 DMA, 11 refresh.

Behaviour:
- Reset values: all grants 0, REF_GO 0, REF_PENDING 0, OWNER 00, state IDLE, timer 0, last-served = DMA, so the CPU wins the first tie.
- Timer:
  - Counts 0..REF_INTERVAL-1 while INIT_BUSY=0; holds at 0 while INIT_BUSY=1.
  - Produces a one-cycle tick on wrap. A tick increments pending, saturating at MAX_PENDING.
  - A completed refresh decrements pending. Tick and decrement in the same cycle leave pending unchanged.
- States: IDLE, GNT_CPU, GNT_DMA, REF_ISSUE, REF_WAIT.
- IDLE: no action while INIT_BUSY=1 or CTRL_IDLE=0. Otherwise, priority:
  1. pending==MAX_PENDING -> REF_ISSUE.
  2. CPU_REQ and DMA_REQ both high -> grant the one not served last (round-robin).
  3. One request high -> grant it.
  4. pending>0 with no requests -> REF_ISSUE (opportunistic).
- Grant timing: the grant asserts on the clock edge after the decision, so latency from request to grant in IDLE is 1 cycle. OWNER updates on the same edge. Exactly one grant may be high at a time (one-hot or zero).
- GNT_CPU / GNT_DMA:
  - The grant holds until CTRL_DONE; it deasserts on the next edge, last-served updates, and the state returns to IDLE.
  - Request deassertion before DONE does not abort the cycle.
  - A tick during a grant only increments pending.
- REF_ISSUE: REF_GO=1 for exactly one cycle, OWNER=11, next state REF_WAIT.
- REF_WAIT: on CTRL_DONE, decrement pending and return to IDLE.
- Back-to-back: IDLE needs at least one cycle between consecutive grants (a dead cycle), which guarantees the controller sees deassertion.
- CTRL_DONE while IDLE is ignored.
- INIT_BUSY rising mid-cycle: the current grant completes normally and no new decisions are made until it falls.
- Reset mid-operation: everything returns to reset values asynchronously and pending debt is discarded; the init sequence refreshes anyway.

Optional Feature:
- Macro: SDRAM_ARB_LOCK_EN.
- Defined:
  - In GNT_CPU, if CPU_LOCK=1 at CTRL_DONE, the CPU grant is retained. State moves to a LOCK_HOLD sub-state with CPU_GNT still high and no dead cycle.
  - The next CPU cycle proceeds when CTRL_IDLE=1.
  - Urgent refresh and DMA both wait until CPU_LOCK falls. Pending still saturates at MAX_PENDING.
  - When CPU_LOCK=0, the grant drops at the next CTRL_DONE, or immediately if already in LOCK_HOLD.
- Not defined: CPU_LOCK is ignored and the port is unused; behaviour is exactly as above.

Decomposition:
- Shared package/include (alongside the SDRAM defines): state encodings and the OWNER encodings OWN_NONE, OWN_CPU, OWN_DMA, OWN_REF.
- One natural sub-module, sdram_refresh_timer: interval counter, tick, and saturating pending counter with increment/decrement and REF_PENDING output. The arbiter FSM stays in the top.

Test Plan:
- Init gating: INIT_BUSY=1 for 100 cycles with CPU_REQ=1 -> no grant and timer at 0; INIT_BUSY falls -> CPU_GNT at cycle+1 with CTRL_IDLE=1.
- Round-robin: CPU_REQ and DMA_REQ held high with 4-cycle DONE responses -> grants alternate CPU, DMA, CPU, DMA, each separated by exactly one dead cycle.
- Opportunistic refresh: REF_INTERVAL=16, no requests -> after 16 cycles pending=1, one REF_GO pulse, and pending returns to 0 after DONE.
- Urgent refresh: DMA saturates the bus until pending=8 -> the next IDLE decision issues REF_GO ahead of the waiting DMA_REQ; pending never exceeds 8.
- Simultaneous tick and refresh DONE in the same cycle -> REF_PENDING unchanged (e.g. 3 stays 3).
- Async reset asserted during GNT_DMA -> DMA_GNT=0, OWNER=00, REF_PENDING=0 immediately, with no clock edge required.
